cache_arbiter: RTL and testbench

Two-port arbiter that shares the single physical-memory port between the instruction cache and the data cache of the LC-3b split-cache memory system. It sits between the two cache instances' `pmem_*` interfaces and the physical memory. It serialises their 128-bit line reads and write-backs with round-robin fairness. Each granted transaction's address, data and operation are latched, so the memory side sees stable signals for the full transaction.

---
 rtl/cache_arbiter.sv | 136 +++++++++++++
 tb/tb_cache_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares one physical-memory port between the I-cache and the D-cache.
// Grants are serialised and round-robin fair. The winner's address, write
// data and operation are latched at grant time, so the memory side sees
// stable values for the whole transaction.
//
// Ports
//   clk, reset                : system clock, async active-high reset
//   i_pmem_read/address       : I-cache line-fill request (held until resp)
//   i_pmem_rdata/resp         : line data and completion pulse to I-cache
//   d_pmem_read/write/address : D-cache fill / write-back request
//   d_pmem_wdata              : D-cache write-back line
//   d_pmem_rdata/resp         : line data and completion pulse to D-cache
//   pmem_read/write           : memory strobes
//   pmem_address/wdata        : latched transaction address / write data
//   pmem_rdata/resp           : memory read data and completion pulse
//
// state  | meaning
// IDLE   | no transaction; arbitrate among pending requests
// BUSY_I | I-cache transaction on the memory port
// BUSY_D | D-cache transaction on the memory port
module cache_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;  // 0 = I, 1 = D
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  op_q, op_d;                  // 0 = read, 1 = write

  logic i_req, d_req, pick_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;
  // On a tie the side that did not win last time goes next.
  assign pick_d = d_req & (~i_req | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          if (pick_d) begin
            state_d = BUSY_D;
            addr_d  = d_pmem_address;
            // Read+write together is illegal; the write wins so a dirty
            // line is never lost.
            if (d_pmem_write) begin
              wdata_d = d_pmem_wdata;
              op_d    = 1'b1;
            end else begin
              op_d    = 1'b0;
            end
          end else begin
            state_d = BUSY_I;
            addr_d  = i_pmem_address;
            op_d    = 1'b0;
          end
        end
      end
      BUSY_I: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
        end
      end
      BUSY_D: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
    end
  end

  // Strobes decode straight from registers, so an async reset drops them
  // immediately.
  assign pmem_read    = (state_q != IDLE) & ~op_q;
  assign pmem_write   = (state_q != IDLE) &  op_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_pmem_resp  = (state_q == BUSY_I) & pmem_resp;
  assign d_pmem_resp  = (state_q == BUSY_D) & pmem_resp;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_pmem_read = 1'b0;
  logic [15:0]  i_pmem_address = '0;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read = 1'b0;
  logic         d_pmem_write = 1'b0;
  logic [15:0]  d_pmem_address = '0;
  logic [127:0] d_pmem_wdata = '0;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata = '0;
  logic         pmem_resp = 1'b0;

  cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int nd_resp = 0;

  task automatic chk_b(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int lat = 0;       // extra BUSY cycles before resp
  int cnt = 0;
  bit spur = 1'b0;   // request one stray resp pulse
  always begin
    @(posedge clk);
    #1;
    if (pmem_resp) begin
      pmem_resp = 1'b0;
      cnt = 0;
    end else if (spur) begin
      pmem_resp = 1'b1;
    end else if (pmem_read || pmem_write) begin
      if (cnt >= lat) begin
        pmem_resp = 1'b1;
        cnt = 0;
      end else begin
        cnt++;
      end
    end else begin
      cnt = 0;
    end
  end

  // ---------------- behavioural model ----------------
  // The port holds at most one transaction record; when free, the next one
  // is chosen from the pending requests with alternation on ties.
  typedef struct {
    bit          active;
    bit          is_d;
    bit          write;
    logic [15:0] addr;
  } txn_t;
  txn_t        cur = '{active: 1'b0, is_d: 1'b0, write: 1'b0, addr: 16'h0};
  bit          prev_was_d = 1'b1;
  logic [127:0] m_wdata = '0;

  task automatic model_clear();
    cur = '{active: 1'b0, is_d: 1'b0, write: 1'b0, addr: 16'h0};
    prev_was_d = 1'b1;
    m_wdata = '0;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      model_clear();
    end else if (!cur.active) begin
      bit want_i, want_d, go_d;
      want_i = i_pmem_read;
      want_d = d_pmem_read || d_pmem_write;
      if (want_i && want_d) go_d = !prev_was_d;
      else                  go_d = want_d;
      if (want_i || want_d) begin
        cur.active = 1'b1;
        cur.is_d   = go_d;
        cur.write  = go_d && d_pmem_write;
        cur.addr   = go_d ? d_pmem_address : i_pmem_address;
        if (cur.write) m_wdata = d_pmem_wdata;
      end
    end else if (pmem_resp) begin
      prev_was_d = cur.is_d;
      cur.active = 1'b0;
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge clk) begin
    if (reset) model_clear();
    chk_b("pmem_read",  pmem_read,  cur.active && !cur.write);
    chk_b("pmem_write", pmem_write, cur.active &&  cur.write);
    chk_b("i_resp", i_pmem_resp, cur.active && !cur.is_d && pmem_resp && !reset);
    chk_b("d_resp", d_pmem_resp, cur.active &&  cur.is_d && pmem_resp && !reset);
    chk_w("i_rdata", i_pmem_rdata, pmem_rdata);
    chk_w("d_rdata", d_pmem_rdata, pmem_rdata);
    if (cur.active || reset) begin
      chk_w("pmem_address", 128'(pmem_address), 128'(cur.addr));
      if (cur.write || reset) chk_w("pmem_wdata", pmem_wdata, m_wdata);
    end
    if (d_pmem_resp) nd_resp++;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_resp(input bit is_d, output int c);
    c = -1;
    for (int n = 0; n < 60; n++) begin
      if (is_d ? d_pmem_resp : i_pmem_resp) begin
        c = cyc;
        break;
      end
      tick();
    end
    if (c < 0) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got no %s resp expected one within 60 cycles", is_d ? "D" : "I");
    end
  endtask

  localparam logic [127:0] LINE_A  = {8{16'hAAAA}};
  localparam logic [127:0] LINE_WB = 128'h0123456789ABCDEF0123456789ABCDEF;

  initial begin
    int c0, c, ci, cd, r1, r2, r3, nd0;
    bit seen;

    // reset state
    #2;
    chk_b("rst_pmem_read", pmem_read, 1'b0);
    chk_b("rst_pmem_write", pmem_write, 1'b0);
    chk_w("rst_pmem_address", 128'(pmem_address), 128'h0);
    chk_w("rst_pmem_wdata", pmem_wdata, 128'h0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // single I read
    lat = 3;
    pmem_rdata = LINE_A;
    nd0 = nd_resp;
    i_pmem_address = 16'h1230;
    i_pmem_read = 1'b1;
    c0 = cyc;
    tick();
    chk_b("i_strobe_n1", pmem_read, 1'b1);
    chk_w("i_addr_n1", 128'(pmem_address), 128'(16'h1230));
    wait_resp(1'b0, c);
    chk_i("i_resp_cycle", c - c0, 4);
    chk_w("i_rdata_line", i_pmem_rdata, LINE_A);
    i_pmem_read = 1'b0;
    tick();
    chk_b("i_strobe_low_after", pmem_read, 1'b0);
    chk_i("i_no_d_resp", nd_resp - nd0, 0);
    tick();

    // D write-back, wdata changed mid-transaction
    d_pmem_address = 16'h4560;
    d_pmem_wdata = LINE_WB;
    d_pmem_write = 1'b1;
    c0 = cyc;
    tick();
    tick();
    d_pmem_wdata = ~LINE_WB;
    wait_resp(1'b1, c);
    chk_i("wb_resp_cycle", c - c0, 4);
    chk_b("wb_strobe", pmem_write, 1'b1);
    chk_w("wb_latched_wdata", pmem_wdata, LINE_WB);
    d_pmem_write = 1'b0;
    tick(); tick();

    // simultaneous requests after reset: I first, D two cycles after resp
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    lat = 1;
    i_pmem_address = 16'h1000;
    d_pmem_address = 16'h2000;
    i_pmem_read = 1'b1;
    d_pmem_read = 1'b1;
    tick();
    chk_w("tie1_i_first", 128'(pmem_address), 128'(16'h1000));
    wait_resp(1'b0, ci);
    i_pmem_read = 1'b0;
    tick();
    chk_b("turnaround_idle", pmem_read, 1'b0);
    tick();
    chk_b("d_after_i_strobe", pmem_read, 1'b1);
    chk_w("d_after_i_addr", 128'(pmem_address), 128'(16'h2000));
    wait_resp(1'b1, cd);
    chk_i("d_resp_after_i", cd - ci, 3);
    d_pmem_read = 1'b0;
    tick();

    // I alone, then a tie: now D goes first
    i_pmem_address = 16'h1010;
    i_pmem_read = 1'b1;
    tick();
    wait_resp(1'b0, c);
    i_pmem_read = 1'b0;
    tick();
    i_pmem_address = 16'h1020;
    d_pmem_address = 16'h2020;
    i_pmem_read = 1'b1;
    d_pmem_read = 1'b1;
    tick();
    chk_w("tie2_d_first", 128'(pmem_address), 128'(16'h2020));
    wait_resp(1'b1, c);
    d_pmem_read = 1'b0;
    tick();
    wait_resp(1'b0, c);
    i_pmem_read = 1'b0;
    tick(); tick();

    // zero-wait memory, D back-to-back, pending I wins the next tie
    lat = 0;
    d_pmem_address = 16'h3000;
    d_pmem_read = 1'b1;
    tick();
    wait_resp(1'b1, r1);
    tick();
    wait_resp(1'b1, r2);
    chk_i("zw_d_period", r2 - r1, 2);
    i_pmem_address = 16'h1040;
    i_pmem_read = 1'b1;
    tick();
    tick();
    chk_w("zw_pending_i_wins", 128'(pmem_address), 128'(16'h1040));
    wait_resp(1'b0, ci);
    chk_i("zw_i_slot", ci - r2, 2);
    i_pmem_read = 1'b0;
    tick();
    wait_resp(1'b1, r3);
    chk_i("zw_d_resumes", r3 - ci, 2);
    d_pmem_read = 1'b0;
    tick(); tick();

    // reset mid-transaction, then a stray resp while idle
    lat = 20;
    nd0 = nd_resp;
    d_pmem_address = 16'h3330;
    d_pmem_read = 1'b1;
    tick();
    tick();
    chk_b("busy_d_before_reset", pmem_read, 1'b1);
    reset = 1'b1;
    d_pmem_read = 1'b0;
    #1;
    chk_b("reset_drops_read", pmem_read, 1'b0);
    chk_w("reset_clears_addr", 128'(pmem_address), 128'h0);
    tick();
    reset = 1'b0;
    tick();
    spur = 1'b1;
    tick();
    spur = 1'b0;
    chk_b("stray_resp_present", pmem_resp, 1'b1);
    chk_b("stray_no_d_resp", d_pmem_resp, 1'b0);
    chk_b("stray_no_i_resp", i_pmem_resp, 1'b0);
    tick();
    chk_i("aborted_no_d_resp", nd_resp - nd0, 0);
    lat = 2;
    i_pmem_address = 16'h5550;
    i_pmem_read = 1'b1;
    tick();
    chk_b("post_reset_i_strobe", pmem_read, 1'b1);
    chk_w("post_reset_i_addr", 128'(pmem_address), 128'(16'h5550));
    wait_resp(1'b0, c);
    i_pmem_read = 1'b0;
    tick(); tick();

    // illegal D read+write: behaves as a write for the whole transaction
    lat = 2;
    d_pmem_address = 16'h7770;
    d_pmem_wdata = 128'hFEDCBA98765432100011223344556677;
    d_pmem_read = 1'b1;
    d_pmem_write = 1'b1;
    tick();
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      chk_b("rw_pmem_write", pmem_write, 1'b1);
      chk_b("rw_pmem_read", pmem_read, 1'b0);
      if (d_pmem_resp) seen = 1'b1;
      else tick();
    end
    chk_b("rw_resp_seen", seen, 1'b1);
    chk_w("rw_wdata", pmem_wdata, 128'hFEDCBA98765432100011223344556677);
    d_pmem_read = 1'b0;
    d_pmem_write = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
